// File: rtl/main_pc.sv
// Program counter for the RAT MCU: holds the current instruction address and
// either loads from a 4-way source mux, increments, or holds on each clock.
module main_pc #(
    parameter int unsigned           WIDTH        = 10,
    parameter logic [WIDTH-1:0]      INTR_VECTOR  = '1,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PC_LD,
    input  logic             PC_INC,
    input  logic [1:0]       PC_MUX_SEL,
    input  logic [WIDTH-1:0] FROM_IMMED,
    input  logic [WIDTH-1:0] FROM_STACK,
    output logic [WIDTH-1:0] PC_COUNT
);

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_RESET = 2'd3
    } pc_sel_t;

    logic [WIDTH-1:0] mux_out;

    // Unknown selects fall through to the reset vector.
    always_comb begin
        mux_out = RESET_VECTOR;
        case (pc_sel_t'(PC_MUX_SEL))
            SEL_IMMED: mux_out = FROM_IMMED;
            SEL_STACK: mux_out = FROM_STACK;
            SEL_INTR:  mux_out = INTR_VECTOR;
            SEL_RESET: mux_out = RESET_VECTOR;
            default:   mux_out = RESET_VECTOR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PC_COUNT <= RESET_VECTOR;
        end else if (PC_LD) begin
            PC_COUNT <= mux_out;
        end else if (PC_INC) begin
            PC_COUNT <= PC_COUNT + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_main_pc.sv
// Self-checking bench for main_pc: directed steps followed by randomized
// cycles compared against a behavioural next-PC model.
module tb_main_pc;

    logic       CLK;
    logic       RST;
    logic       PC_LD;
    logic       PC_INC;
    logic [1:0] PC_MUX_SEL;
    logic [9:0] FROM_IMMED;
    logic [9:0] FROM_STACK;
    logic [9:0] PC_COUNT;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_pc;

    main_pc #(.WIDTH(10), .INTR_VECTOR(10'h3FF), .RESET_VECTOR(10'h000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_LD      (PC_LD),
        .PC_INC     (PC_INC),
        .PC_MUX_SEL (PC_MUX_SEL),
        .FROM_IMMED (FROM_IMMED),
        .FROM_STACK (FROM_STACK),
        .PC_COUNT   (PC_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: what the PC must become after one rising edge with reset high.
    function automatic logic [9:0] ref_next(input logic [9:0] pc, input logic ld,
                                            input logic inc, input logic [1:0] sel,
                                            input logic [9:0] imm, input logic [9:0] stk);
        logic [9:0] src [4];
        int unsigned nxt;
        src[0] = imm;
        src[1] = stk;
        src[2] = 10'h3FF;
        src[3] = 10'h000;
        if (ld) return src[sel];
        if (inc) begin
            nxt = (int'(pc) + 1) % 1024;
            return nxt[9:0];
        end
        return pc;
    endfunction

    task automatic check(input string tag, input logic [9:0] expected);
        checks++;
        assert (PC_COUNT === expected)
        else begin
            errors++;
            $error("FAIL %s: PC_COUNT=%h expected=%h", tag, PC_COUNT, expected);
        end
    endtask

    task automatic drive(input logic ld, input logic inc, input logic [1:0] sel,
                         input logic [9:0] imm, input logic [9:0] stk);
        PC_LD      = ld;
        PC_INC     = inc;
        PC_MUX_SEL = sel;
        FROM_IMMED = imm;
        FROM_STACK = stk;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        // Reset held low with a pending load
        RST = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 10'h155, 10'h000);
        #2;
        check("reset_no_clock", 10'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_held", 10'h000);
        end
        RST = 1'b1;
        tick();
        check("reset_release_load", 10'h155);

        // Increment and wrap
        drive(1'b1, 1'b0, 2'd0, 10'h3FD, 10'h000);
        tick();
        check("load_3fd", 10'h3FD);
        drive(1'b0, 1'b1, 2'd0, 10'h000, 10'h000);
        tick(); check("inc_3fe", 10'h3FE);
        tick(); check("inc_3ff", 10'h3FF);
        tick(); check("inc_wrap_000", 10'h000);
        tick(); check("inc_001", 10'h001);

        // Mux sweep
        drive(1'b1, 1'b0, 2'd0, 10'h0A5, 10'h2C3);
        tick(); check("mux_immed", 10'h0A5);
        PC_MUX_SEL = 2'd1;
        tick(); check("mux_stack", 10'h2C3);
        PC_MUX_SEL = 2'd2;
        tick(); check("mux_intr", 10'h3FF);
        PC_MUX_SEL = 2'd3;
        tick(); check("mux_reset", 10'h000);

        // Priority: load beats increment, then hold
        drive(1'b1, 1'b0, 2'd0, 10'h010, 10'h000);
        tick(); check("load_010", 10'h010);
        drive(1'b1, 1'b1, 2'd1, 10'h000, 10'h200);
        tick(); check("ld_over_inc", 10'h200);
        drive(1'b0, 1'b0, 2'd1, 10'h123, 10'h321);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", 10'h200);
        end

        // Loading the current value leaves it unchanged
        drive(1'b1, 1'b0, 2'd0, 10'h200, 10'h000);
        tick(); check("load_same", 10'h200);

        // Async reset mid-run
        drive(1'b1, 1'b0, 2'd0, 10'h100, 10'h000);
        tick(); check("load_100", 10'h100);
        drive(1'b0, 1'b1, 2'd0, 10'h000, 10'h000);
        tick(); check("inc_101", 10'h101);
        tick(); check("inc_102", 10'h102);
        #2 RST = 1'b0;
        #1 check("async_reset", 10'h000);
        tick(); check("async_reset_hold0", 10'h000);
        tick(); check("async_reset_hold1", 10'h000);
        RST = 1'b1;
        tick(); check("post_reset_inc", 10'h001);

        // Randomized run against the reference model
        exp_pc = 10'h001;
        for (int i = 0; i < 1024; i++) begin
            RST = ($urandom_range(0, 31) != 0);
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
                  10'($urandom), 10'($urandom));
            #1;
            if (!RST) begin
                exp_pc = 10'h000;
                check("rand_async_reset", exp_pc);
            end
            @(posedge CLK);
            if (RST) exp_pc = ref_next(exp_pc, PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK);
            else     exp_pc = 10'h000;
            @(negedge CLK);
            check("rand_step", exp_pc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
